// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg
// Shared definitions for the SPI register-file peripheral: the frame FSM
// state type, the R/W bit encodings and the command-field width helper.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // Command field: one R/W bit followed by the address bits.
    function automatic int frame_width(input int addr_w);
        return 1 + addr_w;
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync
// Brings one asynchronous SPI pin into the clk domain through SYNC_STAGES
// flops and produces single-cycle rise/fall pulses.
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset (flops load RESET_VAL)
//   din   raw asynchronous pin
//   rise  one-cycle pulse on a synchronised 0->1 transition
//   fall  one-cycle pulse on a synchronised 1->0 transition
module spi_edge_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // The history flop holds the last synchroniser stage one cycle later,
    // so a pin change first sampled at edge k produces a pulse that the
    // consumer acts on at edge k+SYNC_STAGES.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign fall = ~sync_q[SYNC_STAGES-1] & hist_q;

endmodule

// File: rtl/spi_reg_peripheral.sv
// spi_reg_peripheral
// SPI mode-0 register file. A frame is R/W bit, ADDR_W address bits, then
// any number of DATA_W words; the address auto-increments after every word.
// Write frames update the register array, read frames shift register
// contents out on cipo. A frame ending mid-field raises frame_err.
// Ports:
//   clk, rst   system clock and synchronous active-high reset
//   ncs        chip select (active low, asynchronous)
//   sclk       SPI clock (idle low, asynchronous)
//   copi       controller-out data, sampled on sclk rising edge
//   cipo       peripheral-out data, MSB first, 0 when cipo_oe is low
//   cipo_oe    high during the data phase of a read frame
//   reg_q      flat register contents, register i at [i*DATA_W +: DATA_W]
//   reg_wr     one-cycle write strobe per register
//   frame_err  one-cycle pulse on a malformed frame
module spi_reg_peripheral
    import spi_reg_pkg::*;
#(
    parameter int                NUM_REGS    = 5,
    parameter int                ADDR_W      = 7,
    parameter int                DATA_W      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ncs,
    input  logic                         sclk,
    input  logic                         copi,
    output logic                         cipo,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic [NUM_REGS-1:0]          reg_wr,
    output logic                         frame_err
);

    localparam int CMD_W = frame_width(ADDR_W);
    localparam int SH_W  = (CMD_W > DATA_W) ? CMD_W : DATA_W;
    localparam int CNT_W = (SH_W > 1) ? $clog2(SH_W) : 1;

    state_t              state;
    state_t              next_state;
    logic                ncs_rise;
    logic                ncs_fall;
    logic                sclk_rise;
    logic                sclk_fall;
    logic [SYNC_STAGES-1:0] copi_q;
    logic                copi_sync;
    logic                take_bit;
    logic                cmd_done;
    logic                word_done;
    logic [SH_W-2:0]     shift_in;
    logic [SH_W-1:0]     next_shift;
    logic [CNT_W-1:0]    bit_cnt;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [ADDR_W-1:0]   rd_addr;
    logic [DATA_W-1:0]   rd_data;
    logic                rw;
    logic [DATA_W-1:0]   out_shift;
    logic                skip_shift;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    spi_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_ncs_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (ncs),
        .rise (ncs_rise),
        .fall (ncs_fall)
    );

    spi_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    // copi only needs its level, so it gets a plain synchroniser chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            copi_q <= '0;
        end else begin
            copi_q <= {copi_q[SYNC_STAGES-2:0], copi};
        end
    end

    assign copi_sync = copi_q[SYNC_STAGES-1];

    // ncs rising wins over a coincident sclk rising edge: the bit is lost.
    always_comb begin
        take_bit   = sclk_rise && !ncs_rise;
        next_shift = {shift_in, copi_sync};
        cmd_addr   = next_shift[ADDR_W-1:0];
        cmd_done   = (state == CMD)  && take_bit && (bit_cnt == CNT_W'(CMD_W - 1));
        word_done  = (state == DATA) && take_bit && (bit_cnt == CNT_W'(DATA_W - 1));
        rd_addr    = (state == CMD) ? cmd_addr : addr;
        rd_data    = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_data = regs[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (ncs_fall) next_state = CMD;
            CMD: begin
                if (ncs_rise) begin
                    next_state = IDLE;
                end else if (cmd_done) begin
                    next_state = DATA;
                end
            end
            DATA: if (ncs_rise) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: counters, shifters and the register array. bit_cnt counts
    // bits within the current field and returns to 0 at each field boundary,
    // so a nonzero count at ncs rising marks a malformed frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
            reg_wr     <= '0;
            frame_err  <= 1'b0;
            bit_cnt    <= '0;
            shift_in   <= '0;
            addr       <= '0;
            rw         <= RW_READ;
            out_shift  <= '0;
            skip_shift <= 1'b0;
            cipo_oe    <= 1'b0;
        end else begin
            reg_wr    <= '0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (ncs_fall) begin
                        bit_cnt <= '0;
                        cipo_oe <= 1'b0;
                    end
                end
                CMD: begin
                    if (ncs_rise) begin
                        frame_err <= (bit_cnt != '0);
                        cipo_oe   <= 1'b0;
                    end else if (take_bit) begin
                        shift_in <= next_shift[SH_W-2:0];
                        if (cmd_done) begin
                            bit_cnt <= '0;
                            rw      <= next_shift[CMD_W-1];
                            if (next_shift[CMD_W-1] == RW_READ) begin
                                out_shift  <= rd_data;
                                skip_shift <= 1'b1;
                                cipo_oe    <= 1'b1;
                                addr       <= cmd_addr + ADDR_W'(1);
                            end else begin
                                addr <= cmd_addr;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (ncs_rise) begin
                        frame_err <= (bit_cnt != '0);
                        cipo_oe   <= 1'b0;
                    end else begin
                        if (take_bit) begin
                            shift_in <= next_shift[SH_W-2:0];
                            if (word_done) begin
                                bit_cnt <= '0;
                                addr    <= addr + ADDR_W'(1);
                                if (rw == RW_WRITE) begin
                                    for (int i = 0; i < NUM_REGS; i++) begin
                                        if (addr == ADDR_W'(i)) begin
                                            regs[i]   <= next_shift[DATA_W-1:0];
                                            reg_wr[i] <= 1'b1;
                                        end
                                    end
                                end else begin
                                    out_shift  <= rd_data;
                                    skip_shift <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                        // The first falling edge after a load leaves the MSB
                        // on cipo so the controller samples it on the next rise.
                        if (sclk_fall && cipo_oe) begin
                            if (skip_shift) begin
                                skip_shift <= 1'b0;
                            end else begin
                                out_shift <= {out_shift[DATA_W-2:0], 1'b0};
                            end
                        end
                    end
                end
                default: begin
                    cipo_oe <= 1'b0;
                end
            endcase
        end
    end

    assign cipo = cipo_oe & out_shift[DATA_W-1];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
        assign reg_q[g*DATA_W +: DATA_W] = regs[g];
    end

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// tb_spi_reg_peripheral
// Drives SPI frames at the pins and compares register contents, write
// strobes, error pulses and read data against expected values from a
// vector table and from a frame-level reference model.
module tb_spi_reg_peripheral;

    localparam int NUM_REGS = 5;
    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 8;
    localparam int HALF     = 6;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        ncs;
    logic                        sclk;
    logic                        copi;
    logic                        cipo;
    logic                        cipo_oe;
    logic [NUM_REGS*DATA_W-1:0]  reg_q;
    logic [NUM_REGS-1:0]         reg_wr;
    logic                        frame_err;

    spi_reg_peripheral #(
        .NUM_REGS    (NUM_REGS),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .SYNC_STAGES (2),
        .RESET_VAL   (8'h00)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ncs       (ncs),
        .sclk      (sclk),
        .copi      (copi),
        .cipo      (cipo),
        .cipo_oe   (cipo_oe),
        .reg_q     (reg_q),
        .reg_wr    (reg_wr),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int wr_pulses  = 0;
    int wr_multi   = 0;
    int err_pulses = 0;
    int oe_bad     = 0;

    logic [7:0] tx_words [8];
    logic [7:0] rx_words [8];
    logic [7:0] exp_rx   [8];
    logic [7:0] m        [NUM_REGS];
    int         exp_err;
    int         exp_wr;

    typedef struct {
        logic        rw;
        int          addr;
        int          nwords;
        int          cmd_bits;
        int          extra;
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic [7:0]  d2;
        int          exp_err;
        int          exp_wr;
        logic [39:0] exp_q;
        logic [7:0]  exp_r0;
        logic [7:0]  exp_r1;
    } vec_t;

    vec_t vecs [11];

    // Pulse counters, sampled on the falling clk edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (reg_wr != '0) wr_pulses++;
            if ($countones(reg_wr) > 1) wr_multi++;
            if (frame_err) err_pulses++;
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sendBit(input logic b, input logic exp_oe, output logic rx);
        copi = b;
        waitClk(HALF);
        rx = cipo;
        if (cipo_oe !== exp_oe) oe_bad++;
        sclk = 1'b1;
        waitClk(HALF);
        sclk = 1'b0;
    endtask

    // One complete frame at the pins. cmd_bits < 8 truncates the command,
    // extra appends a partial data word, collide raises ncs together with
    // the last sclk rising edge of the last word.
    task automatic applyStimulus(input logic rw, input int addr, input int nwords,
                                 input int cmd_bits, input int extra, input logic collide);
        logic [7:0] cmd;
        logic       r;
        cmd = {rw, 7'(addr)};
        ncs = 1'b0;
        waitClk(HALF);
        for (int i = 0; i < cmd_bits; i++) sendBit(cmd[7-i], 1'b0, r);
        if (cmd_bits == 8) begin
            for (int w = 0; w < nwords; w++) begin
                for (int b = 0; b < 8; b++) begin
                    if (collide && w == nwords - 1 && b == 7) begin
                        copi = tx_words[w][0];
                        waitClk(HALF);
                        sclk = 1'b1;
                        ncs  = 1'b1;
                        waitClk(HALF);
                        sclk = 1'b0;
                    end else begin
                        sendBit(rw ? tx_words[w][7-b] : 1'($urandom), !rw, r);
                        rx_words[w][7-b] = r;
                    end
                end
            end
            for (int e = 0; e < extra; e++) sendBit(1'($urandom), !rw, r);
        end
        if (!collide) begin
            waitClk(HALF);
            ncs = 1'b1;
        end
        waitClk(12);
        if (cipo_oe !== 1'b0) oe_bad++;
    endtask

    // Frame-level reference: walk the words with a wrapping address.
    task automatic modelFrame(input logic rw, input int addr, input int nwords,
                              input int cmd_bits, input int extra, input logic collide);
        int a;
        int n;
        exp_err = ((cmd_bits > 0 && cmd_bits < 8) || (cmd_bits == 8 && extra > 0) || collide) ? 1 : 0;
        exp_wr  = 0;
        if (cmd_bits == 8) begin
            a = addr;
            n = collide ? nwords - 1 : nwords;
            for (int w = 0; w < n; w++) begin
                if (rw) begin
                    if (a < NUM_REGS) begin
                        m[a] = tx_words[w];
                        exp_wr++;
                    end
                end else begin
                    exp_rx[w] = (a < NUM_REGS) ? m[a] : 8'h00;
                end
                a = (a + 1) % (1 << ADDR_W);
            end
        end
    endtask

    function automatic logic [39:0] modelQ();
        logic [39:0] q;
        for (int i = 0; i < NUM_REGS; i++) q[i*8 +: 8] = m[i];
        return q;
    endfunction

    task automatic runFrame(input string name, input logic rw, input int addr, input int nwords,
                            input int cmd_bits, input int extra, input logic collide);
        int wr0, err0, oe0;
        wr0 = wr_pulses; err0 = err_pulses; oe0 = oe_bad;
        modelFrame(rw, addr, nwords, cmd_bits, extra, collide);
        applyStimulus(rw, addr, nwords, cmd_bits, extra, collide);
        checkOutput({name, " err"}, 64'(err_pulses - err0), 64'(exp_err));
        checkOutput({name, " wr"}, 64'(wr_pulses - wr0), 64'(exp_wr));
        checkOutput({name, " reg_q"}, 64'(reg_q), 64'(modelQ()));
        checkOutput({name, " oe"}, 64'(oe_bad - oe0), 64'(0));
        if (!rw && cmd_bits == 8) begin
            for (int w = 0; w < nwords; w++)
                checkOutput($sformatf("%s rx%0d", name, w), 64'(rx_words[w]), 64'(exp_rx[w]));
        end
    endtask

    initial begin
        int wr0, err0, oe0;
        logic r;
        logic rw_r;
        int addr_r, nw_r, cb_r, ex_r;

        //            rw   addr nw cb ex  d0     d1     d2     err wr  exp_q            r0     r1
        vecs[0]  = '{1'b1,   2, 1, 8, 0, 8'hA5, 8'h00, 8'h00, 0, 1, 40'h0000A50000, 8'h00, 8'h00};
        vecs[1]  = '{1'b1,   3, 3, 8, 0, 8'h11, 8'h22, 8'h33, 0, 2, 40'h2211A50000, 8'h00, 8'h00};
        vecs[2]  = '{1'b1,   1, 1, 8, 0, 8'hC3, 8'h00, 8'h00, 0, 1, 40'h2211A5C300, 8'h00, 8'h00};
        vecs[3]  = '{1'b0,   1, 2, 8, 0, 8'h00, 8'h00, 8'h00, 0, 0, 40'h2211A5C300, 8'hC3, 8'hA5};
        vecs[4]  = '{1'b1,   0, 0, 8, 4, 8'h00, 8'h00, 8'h00, 1, 0, 40'h2211A5C300, 8'h00, 8'h00};
        vecs[5]  = '{1'b1,   0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 40'h2211A5C300, 8'h00, 8'h00};
        vecs[6]  = '{1'b1,   0, 0, 5, 0, 8'h00, 8'h00, 8'h00, 1, 0, 40'h2211A5C300, 8'h00, 8'h00};
        vecs[7]  = '{1'b1,   4, 1, 8, 3, 8'h5A, 8'h00, 8'h00, 1, 1, 40'h5A11A5C300, 8'h00, 8'h00};
        vecs[8]  = '{1'b0,   4, 3, 8, 0, 8'h00, 8'h00, 8'h00, 0, 0, 40'h5A11A5C300, 8'h5A, 8'h00};
        vecs[9]  = '{1'b1, 127, 2, 8, 0, 8'h77, 8'h88, 8'h00, 0, 1, 40'h5A11A5C388, 8'h00, 8'h00};
        vecs[10] = '{1'b0, 127, 2, 8, 0, 8'h00, 8'h00, 8'h00, 0, 0, 40'h5A11A5C388, 8'h00, 8'h88};

        rst = 1'b1; ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
        waitClk(4);
        rst = 1'b0;
        waitClk(1);
        checkOutput("reset reg_q", 64'(reg_q), 64'(0));
        checkOutput("reset reg_wr", 64'(reg_wr), 64'(0));
        checkOutput("reset frame_err", 64'(frame_err), 64'(0));
        checkOutput("reset cipo", 64'(cipo), 64'(0));
        checkOutput("reset cipo_oe", 64'(cipo_oe), 64'(0));
        waitClk(10);

        $display("[TB] vector table");
        for (int i = 0; i < 11; i++) begin
            tx_words[0] = vecs[i].d0;
            tx_words[1] = vecs[i].d1;
            tx_words[2] = vecs[i].d2;
            wr0 = wr_pulses; err0 = err_pulses; oe0 = oe_bad;
            applyStimulus(vecs[i].rw, vecs[i].addr, vecs[i].nwords,
                          vecs[i].cmd_bits, vecs[i].extra, 1'b0);
            checkOutput($sformatf("vec%0d err", i), 64'(err_pulses - err0), 64'(vecs[i].exp_err));
            checkOutput($sformatf("vec%0d wr", i), 64'(wr_pulses - wr0), 64'(vecs[i].exp_wr));
            checkOutput($sformatf("vec%0d reg_q", i), 64'(reg_q), 64'(vecs[i].exp_q));
            checkOutput($sformatf("vec%0d oe", i), 64'(oe_bad - oe0), 64'(0));
            if (!vecs[i].rw && vecs[i].nwords >= 1)
                checkOutput($sformatf("vec%0d rx0", i), 64'(rx_words[0]), 64'(vecs[i].exp_r0));
            if (!vecs[i].rw && vecs[i].nwords >= 2)
                checkOutput($sformatf("vec%0d rx1", i), 64'(rx_words[1]), 64'(vecs[i].exp_r1));
        end

        $display("[TB] reset in the middle of a frame");
        ncs = 1'b0;
        waitClk(HALF);
        sendBit(1'b1, 1'b0, r);
        sendBit(1'b0, 1'b0, r);
        sendBit(1'b0, 1'b0, r);
        sendBit(1'b0, 1'b0, r);
        rst = 1'b1;
        waitClk(3);
        rst = 1'b0;
        waitClk(1);
        checkOutput("midrst reg_q", 64'(reg_q), 64'(0));
        checkOutput("midrst cipo_oe", 64'(cipo_oe), 64'(0));
        for (int i = 0; i < NUM_REGS; i++) m[i] = 8'h00;
        wr0 = wr_pulses; err0 = err_pulses;
        for (int b = 0; b < 8; b++) sendBit(1'($urandom), 1'b0, r);
        waitClk(HALF);
        checkOutput("midrst wr", 64'(wr_pulses - wr0), 64'(0));
        checkOutput("midrst err", 64'(err_pulses - err0), 64'(0));
        ncs = 1'b1;
        waitClk(12);
        checkOutput("midrst end err", 64'(err_pulses - err0), 64'(0));
        checkOutput("midrst reg_q after", 64'(reg_q), 64'(0));
        tx_words[0] = 8'h3C;
        runFrame("post-reset write", 1'b1, 0, 1, 8, 0, 1'b0);
        tx_words[0] = 8'hC3;
        runFrame("preload reg1", 1'b1, 1, 1, 8, 0, 1'b0);
        runFrame("readback", 1'b0, 1, 2, 8, 0, 1'b0);

        $display("[TB] ncs/sclk collision");
        tx_words[0] = 8'h99;
        runFrame("collision", 1'b1, 1, 1, 8, 0, 1'b1);

        $display("[TB] random frames");
        for (int n = 0; n < 30; n++) begin
            rw_r   = 1'($urandom);
            addr_r = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(120, 127);
            nw_r   = $urandom_range(1, 3);
            cb_r   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : 8;
            ex_r   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            for (int w = 0; w < 8; w++) tx_words[w] = 8'($urandom);
            runFrame($sformatf("rand%0d", n), rw_r, addr_r, nw_r, cb_r, ex_r, 1'b0);
        end

        checkOutput("multi-bit reg_wr", 64'(wr_multi), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
